// File: rtl/despachador.sv
// Dispatcher: drains an upstream FIFO and routes each word to one of four
// destinations selected by its top two bits, with threshold programming and a sticky error state.
module despachador #(
  parameter int unsigned tamano_datos = 10,
  parameter int unsigned num_destinos = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [7:0]                umbral_alto_in,
  input  logic [7:0]                umbral_bajo_in,
  input  logic                      fifo_empty,
  input  logic                      fifo_error,
  input  logic [tamano_datos-1:0]   fifo_data_out,
  input  logic [num_destinos-1:0]   dest_almost_full,
  output logic                      fifo_read_enable,
  output logic [7:0]                umbral_alto,
  output logic [7:0]                umbral_bajo,
  output logic [num_destinos-1:0]   dest_push,
  output logic [tamano_datos-3:0]   dest_data,
  output logic [2:0]                estado,
  output logic                      error_out,
  output logic [7:0]                word_count
);

  localparam int unsigned SEL_W  = $clog2(num_destinos);
  localparam int unsigned DATA_W = tamano_datos - SEL_W;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t                   r_state;
  logic                     r_pend;
  logic [7:0]               r_umbral_alto;
  logic [7:0]               r_umbral_bajo;
  logic [num_destinos-1:0]  r_push;
  logic [DATA_W-1:0]        r_data;
  logic                     r_err;
  logic [7:0]               r_count;

  logic                     w_rd;
  logic [SEL_W-1:0]         w_sel;
  logic [num_destinos-1:0]  w_onehot;

  // A read is only issued while streaming with no upstream or downstream obstacle.
  assign w_rd = (r_state == S_ACTIVE) && !fifo_empty && !fifo_error && !(|dest_almost_full);

  assign w_sel = fifo_data_out[tamano_datos-1 -: SEL_W];

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_RESET;
      r_pend        <= 1'b0;
      r_umbral_alto <= 8'd0;
      r_umbral_bajo <= 8'd0;
      r_push        <= '0;
      r_data        <= '0;
      r_err         <= 1'b0;
      r_count       <= 8'd0;
    end else begin
      r_pend <= w_rd;
      r_push <= '0;

      // The word read last cycle is on fifo_data_out now; an upstream error discards it.
      if (r_pend && !fifo_error && (r_state == S_ACTIVE)) begin
        r_push  <= w_onehot;
        r_data  <= fifo_data_out[DATA_W-1:0];
        r_count <= r_count + 8'd1;
      end

      case (r_state)
        S_RESET: r_state <= S_INIT;
        S_INIT: begin
          if (init) begin
            r_umbral_alto <= umbral_alto_in;
            r_umbral_bajo <= umbral_bajo_in;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (fifo_error) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
          end else if (init) begin
            r_state <= S_INIT;
          end else if (!fifo_empty) begin
            r_state <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (fifo_error) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
          end else if (fifo_empty && !r_pend) begin
            r_state <= S_IDLE;
          end
        end
        S_ERROR: r_err <= 1'b1;
        default: r_state <= S_RESET;
      endcase
    end
  end

  assign fifo_read_enable = w_rd;
  assign umbral_alto      = r_umbral_alto;
  assign umbral_bajo      = r_umbral_bajo;
  assign dest_push        = r_push;
  assign dest_data        = r_data;
  assign estado           = r_state;
  assign error_out        = r_err;
  assign word_count       = r_count;

endmodule
